// File: rtl/q2_panel_pkg.sv
// Shared definitions for the q2 front panel: FSM state encoding, switch
// indices and the fixed priority order among panel presses.
package q2_panel_pkg;

  localparam logic [2:0] S_HALT      = 3'd0;
  localparam logic [2:0] S_RUN       = 3'd1;
  localparam logic [2:0] S_STOP_WAIT = 3'd2;
  localparam logic [2:0] S_STEP_A    = 3'd3;
  localparam logic [2:0] S_STEP_B    = 3'd4;

  // Switch slots; the lower the index, the higher the press priority in HALT.
  localparam int SW_START = 0;
  localparam int SW_STEP  = 1;
  localparam int SW_LD    = 2;
  localparam int SW_DEP   = 3;
  localparam int SW_INCP  = 4;
  localparam int SW_STOP  = 5;
  localparam int NUM_SW   = 6;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_START,
    ACT_STEP,
    ACT_LD,
    ACT_DEP,
    ACT_INCP
  } action_e;

  function automatic action_e pick_action(input logic [SW_INCP:0] act_press);
    if (act_press[SW_START]) return ACT_START;
    if (act_press[SW_STEP])  return ACT_STEP;
    if (act_press[SW_LD])    return ACT_LD;
    if (act_press[SW_DEP])   return ACT_DEP;
    if (act_press[SW_INCP])  return ACT_INCP;
    return ACT_NONE;
  endfunction

endpackage

// File: rtl/q2_debounce.sv
// One panel switch: two-flop synchroniser, stability counter, debounced
// level and a single-cycle press pulse on each rising level change.
module q2_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: all state here updates with non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE)) begin
          level <= ~level;
          press <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/q2_panel.sv
// q2 front-panel controller: debounced switches, panel address pointer,
// load/deposit/increment cycles and the run/halt/single-step state machine.
module q2_panel
  import q2_panel_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             ld_sw,
  input  logic             dep_sw,
  input  logic             incp_sw,
  input  logic             start_sw,
  input  logic             step_sw,
  input  logic             stop_sw,
  input  logic             cpu_idle,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_value,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic             run
);

  logic [NUM_SW-1:0] raw;
  logic [NUM_SW-1:0] level;
  logic [NUM_SW-1:0] press;
  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [WIDTH-1:0]  ptr;
  logic [WIDTH-1:0]  ptr_nxt;
  action_e           act;
  logic              unused_bits;

  assign raw = {stop_sw, incp_sw, dep_sw, ld_sw, step_sw, start_sw};

  for (genvar g = 0; g < NUM_SW; g++) begin : g_db
    q2_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk   (clk),
      .rst   (rst),
      .in    (raw[g]),
      .level (level[g]),
      .press (press[g])
    );
  end

  // Only the stop switch is used as a level; it never acts as a HALT press.
  assign unused_bits = ^{level[SW_INCP:0], press[SW_STOP]};

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    act       = pick_action(press[SW_INCP:0]);
    state_nxt = state;
    ptr_nxt   = ptr;
    pc_load   = 1'b0;
    mem_we    = 1'b0;
    case (state)
      S_HALT: begin
        case (act)
          ACT_START: begin
            if (!level[SW_STOP]) begin
              pc_load   = 1'b1;
              state_nxt = S_RUN;
            end
          end
          ACT_STEP: begin
            pc_load   = 1'b1;
            state_nxt = S_STEP_A;
          end
          ACT_LD:   ptr_nxt = sw;
          ACT_DEP: begin
            // The strobe sees the old ptr; the increment lands as it ends.
            mem_we  = 1'b1;
            ptr_nxt = ptr + WIDTH'(1);
          end
          ACT_INCP: ptr_nxt = ptr + WIDTH'(1);
          default:  ;
        endcase
      end
      S_RUN:       if (press[SW_STOP]) state_nxt = S_STOP_WAIT;
      S_STOP_WAIT: if (cpu_idle)       state_nxt = S_HALT;
      S_STEP_A:    if (!cpu_idle)      state_nxt = S_STEP_B;
      S_STEP_B:    if (cpu_idle)       state_nxt = S_HALT;
      default:                         state_nxt = S_HALT;
    endcase
    // A reset cycle must never leak a strobe to the CPU or memory.
    if (rst) begin
      pc_load = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_HALT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  assign pc_value  = ptr;
  assign mem_addr  = ptr;
  assign mem_wdata = mem_we ? sw : '0;
  assign run       = (state != S_HALT);

endmodule

// File: tb/tb_q2_panel.sv
// Self-checking bench for q2_panel (WIDTH=12, DEBOUNCE=4): vector table,
// hand-written run/step/collision/reset sequences and random panel operations.
module tb_q2_panel;

  localparam int W     = 12;
  localparam int D     = 4;
  localparam int HOLD  = D + 6;
  localparam int SETTLE = D + 4;
  localparam int LAT   = D + 3;

  localparam int M_START = 1;
  localparam int M_STEP  = 2;
  localparam int M_LD    = 4;
  localparam int M_DEP   = 8;
  localparam int M_INCP  = 16;
  localparam int M_STOP  = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw;
  logic         ld_sw, dep_sw, incp_sw, start_sw, step_sw, stop_sw, cpu_idle;
  logic         pc_load, mem_we, run;
  logic [W-1:0] pc_value, mem_addr, mem_wdata;

  q2_panel #(.WIDTH(W), .DEBOUNCE(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .ld_sw     (ld_sw),
    .dep_sw    (dep_sw),
    .incp_sw   (incp_sw),
    .start_sw  (start_sw),
    .step_sw   (step_sw),
    .stop_sw   (stop_sw),
    .cpu_idle  (cpu_idle),
    .pc_load   (pc_load),
    .pc_value  (pc_value),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .run       (run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  pc_q[$];
  int  both_cnt = 0;

  always @(negedge clk) begin
    if (mem_we) wr_q.push_back('{cyc_cnt, mem_addr, mem_wdata});
    if (pc_load) pc_q.push_back(int'(pc_value));
    if (mem_we && pc_load) both_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_sw(input int mask);
    start_sw = mask[0];
    step_sw  = mask[1];
    ld_sw    = mask[2];
    dep_sw   = mask[3];
    incp_sw  = mask[4];
    stop_sw  = mask[5];
  endtask

  task automatic do_op(input int mask, input logic [W-1:0] val, output int t0);
    sw = val;
    set_sw(mask);
    t0 = cyc_cnt;
    wait_cycles(HOLD);
    set_sw(0);
    wait_cycles(SETTLE);
  endtask

  // One panel operation, checked against the expected pointer and write.
  task automatic op_check(input string name, input int mask, input logic [W-1:0] val,
                          input int exp_ptr, input int exp_nw,
                          input int exp_addr, input int exp_data);
    int n0;
    int t0;
    n0 = wr_q.size();
    do_op(mask, val, t0);
    check({name, "_ptr"}, mem_addr, exp_ptr);
    check({name, "_nwrites"}, wr_q.size() - n0, exp_nw);
    if (exp_nw == 1 && wr_q.size() > n0) begin
      check({name, "_waddr"}, wr_q[n0].addr, exp_addr);
      check({name, "_wdata"}, wr_q[n0].data, exp_data);
      check({name, "_wcycle"}, wr_q[n0].cyc, t0 + LAT);
    end
  endtask

  typedef struct {
    int           mask;
    logic [W-1:0] val;
    int           exp_ptr;
    int           exp_nw;
    int           exp_addr;
    int           exp_data;
  } vec_t;

  vec_t vecs[6];
  int   model_ptr;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n0;
    int pc_n0;
    int op;
    logic [W-1:0] val;
    int idle_pat[4];

    vecs[0] = '{M_LD,   12'h100, 'h100, 0, 0,     0};
    vecs[1] = '{M_DEP,  12'hABC, 'h101, 1, 'h100, 'hABC};
    vecs[2] = '{M_DEP,  12'h123, 'h102, 1, 'h101, 'h123};
    vecs[3] = '{M_LD,   12'hFFF, 'hFFF, 0, 0,     0};
    vecs[4] = '{M_INCP, 12'h555, 'h000, 0, 0,     0};
    vecs[5] = '{M_DEP,  12'h7E7, 'h001, 1, 'h000, 'h7E7};

    rst = 1'b1;
    sw = '0;
    set_sw(0);
    cpu_idle = 1'b0;
    wait_cycles(3);
    check("reset_run", run, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_pc_load", pc_load, 0);
    check("reset_ptr", mem_addr, 0);
    check("reset_wdata", mem_wdata, 0);
    rst = 1'b0;
    wait_cycles(2);

    // Vector table: load, deposit and increment including pointer wrap.
    for (int i = 0; i < 6; i++)
      op_check($sformatf("vec%0d", i), vecs[i].mask, vecs[i].val, vecs[i].exp_ptr,
               vecs[i].exp_nw, vecs[i].exp_addr, vecs[i].exp_data);
    model_ptr = 'h001;

    // Glitch of D-1 cycles never becomes a press.
    n0 = wr_q.size();
    sw = 12'h0F0;
    dep_sw = 1'b1;
    wait_cycles(D - 1);
    dep_sw = 1'b0;
    wait_cycles(3 * D);
    check("glitch_no_write", wr_q.size() - n0, 0);
    check("glitch_ptr", mem_addr, model_ptr);

    // Long hold: exactly one write, at the debounce latency.
    n0 = wr_q.size();
    sw = 12'h5A5;
    dep_sw = 1'b1;
    t0 = cyc_cnt;
    wait_cycles(4 * D + 10);
    check("hold_one_write", wr_q.size() - n0, 1);
    if (wr_q.size() > n0) begin
      check("hold_wcycle", wr_q[n0].cyc, t0 + LAT);
      check("hold_waddr", wr_q[n0].addr, model_ptr);
    end
    dep_sw = 1'b0;
    wait_cycles(SETTLE);
    model_ptr = (model_ptr + 1) % (1 << W);
    check("hold_ptr", mem_addr, model_ptr);

    // Random load/deposit/increment against the pointer model.
    for (int i = 0; i < 30; i++) begin
      op  = $urandom_range(0, 2);
      val = W'($urandom);
      if (op == 0) begin
        op_check($sformatf("rnd%0d_ld", i), M_LD, val, val, 0, 0, 0);
        model_ptr = val;
      end else if (op == 1) begin
        op_check($sformatf("rnd%0d_dep", i), M_DEP, val, (model_ptr + 1) % (1 << W), 1,
                 model_ptr, val);
        model_ptr = (model_ptr + 1) % (1 << W);
      end else begin
        op_check($sformatf("rnd%0d_incp", i), M_INCP, val, (model_ptr + 1) % (1 << W), 0, 0, 0);
        model_ptr = (model_ptr + 1) % (1 << W);
      end
    end

    // Run, ignored panel ops while running, stop waiting for cpu_idle.
    cpu_idle = 1'b0;
    pc_n0 = pc_q.size();
    sw = '0;
    set_sw(M_START);
    wait_cycles(LAT);
    check("start_pc_load", pc_load, 1);
    check("start_pc_value", pc_value, model_ptr);
    check("start_run_before", run, 0);
    wait_cycles(1);
    check("start_run_after", run, 1);
    check("start_pc_load_once", pc_load, 0);
    wait_cycles(4);
    set_sw(0);
    wait_cycles(SETTLE);
    check("start_pc_count", pc_q.size() - pc_n0, 1);
    n0 = wr_q.size();
    do_op(M_LD, 12'h0AA, t0);
    check("ld_in_run_ptr", mem_addr, model_ptr);
    do_op(M_DEP, 12'h0BB, t0);
    check("dep_in_run_nw", wr_q.size() - n0, 0);
    do_op(M_STOP, '0, t0);
    check("stop_busy_run", run, 1);
    cpu_idle = 1'b1;
    check("stop_idle_cycle_run", run, 1);
    wait_cycles(1);
    cpu_idle = 1'b0;
    check("stop_halted", run, 0);
    wait_cycles(2);
    check("stop_stays_halted", run, 0);

    // Start is refused while the stop switch is held.
    set_sw(M_STOP);
    wait_cycles(D + 5);
    pc_n0 = pc_q.size();
    do_op(M_STOP | M_START, '0, t0);
    check("start_blocked_pc", pc_q.size() - pc_n0, 0);
    check("start_blocked_run", run, 0);

    // Single step with idle pattern 1,0,0,1; a deposit during it is ignored.
    idle_pat = '{1, 0, 0, 1};
    cpu_idle = 1'b1;
    n0 = wr_q.size();
    sw = 12'h777;
    set_sw(M_STEP);
    t0 = cyc_cnt;
    wait_cycles(1);
    set_sw(M_STEP | M_DEP);
    wait_cycles(LAT - 1);
    check("step_pc_load", pc_load, 1);
    check("step_pc_value", pc_value, model_ptr);
    check("step_run_before", run, 0);
    for (int i = 0; i < 4; i++) begin
      wait_cycles(1);
      cpu_idle = idle_pat[i][0];
      check($sformatf("step_run_%0d", i), run, 1);
    end
    wait_cycles(1);
    check("step_done_run", run, 0);
    wait_cycles(HOLD);
    set_sw(0);
    wait_cycles(SETTLE);
    check("step_dep_ignored", wr_q.size() - n0, 0);
    check("step_ptr", mem_addr, model_ptr);
    check("step_stays_halted", run, 0);

    // Start and deposit collide: start wins, no write, pointer unchanged.
    cpu_idle = 1'b0;
    n0 = wr_q.size();
    pc_n0 = pc_q.size();
    sw = 12'h3C3;
    set_sw(M_START | M_DEP);
    wait_cycles(LAT);
    check("coll_pc_load", pc_load, 1);
    check("coll_mem_we", mem_we, 0);
    wait_cycles(HOLD - LAT);
    set_sw(0);
    wait_cycles(SETTLE);
    check("coll_nw", wr_q.size() - n0, 0);
    check("coll_npc", pc_q.size() - pc_n0, 1);
    check("coll_ptr", mem_addr, model_ptr);
    check("coll_run", run, 1);

    // Reset while running.
    rst = 1'b1;
    wait_cycles(1);
    check("rst_run", run, 0);
    check("rst_ptr", mem_addr, 0);
    rst = 1'b0;
    wait_cycles(3);
    check("rst_after_run", run, 0);

    check("never_both_strobes", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q2_panel.md
Name: q2_panel

Overview:
Front-panel controller for the q2 CPU, generalised to any word width and debounce depth. It sits between the raw panel switches and the CPU/memory. It debounces every momentary switch and keeps the panel address pointer. It generates load-address, deposit and increment-pointer memory cycles, and owns the run/halt state machine, including single-step mode and a clean stop at an instruction boundary.

Parameters:
WIDTH, 12, word and address width in bits
DEBOUNCE, 16, consecutive stable cycles required before a debounced level changes (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sw  in  WIDTH  data/address switches, sampled directly (not debounced)
ld_sw  in  1  load-address switch
dep_sw  in  1  deposit switch
incp_sw  in  1  increment-pointer switch
start_sw  in  1  start switch
step_sw  in  1  single-step switch
stop_sw  in  1  stop switch
cpu_idle  in  1  CPU is at an instruction boundary
pc_load  out  1  one-cycle pulse: CPU loads PC from pc_value
pc_value  out  WIDTH  start address, equals ptr
mem_addr  out  WIDTH  panel memory address, equals ptr
mem_wdata  out  WIDTH  panel write data
mem_we  out  1  one-cycle panel write strobe
run  out  1  CPU clock enable

Behaviour:
Reset:
- clk is the only clock; rst is synchronous, active-high.
- On reset: ptr=0, state=HALT, run=0, pc_load=0, mem_we=0, mem_wdata=0.
- All synchronisers, debounced levels and counters clear to 0.

Debounce (per switch):
- Two-flop synchroniser feeds a counter.
- Counter increments while the synchronised input differs from the debounced level, and clears otherwise.
- At count DEBOUNCE the level flips and the counter clears.
- Press = one-cycle pulse on a 0->1 level change.
- Timing: input high from before edge k and held gives a press high in the cycle after edge k+DEBOUNCE+2.
- Glitches shorter than DEBOUNCE cycles produce no press.
- A switch held through reset gives one press DEBOUNCE+2 cycles after rst falls.

FSM states: HALT, RUN, STOP_WAIT, STEP_A, STEP_B.

HALT (run=0), at most one action per cycle, priority start > step > ld > dep > incp; lower-priority presses in the same cycle are dropped:
- start press with stop level=0: pc_load=1 for one cycle, ->RUN.
- start press with stop level=1: ignored.
- step press: pc_load=1, ->STEP_A.
- ld press: ptr<=sw.
- dep press: mem_we=1 for one cycle with mem_addr=ptr (old) and mem_wdata=sw; ptr<=ptr+1 on the same edge as the strobe ends.
- incp press: ptr<=ptr+1.
- ptr wraps modulo 2^WIDTH (all-ones +1 -> 0).

RUN (run=1):
- stop press -> STOP_WAIT.
- ld/dep/incp/start/step presses are ignored.

STOP_WAIT (run=1):
- Stays until cpu_idle=1.
- On the cycle cpu_idle=1 is sampled: ->HALT, run=0 from the next cycle.
- Other presses are ignored.

STEP_A (run=1):
- Waits for cpu_idle=0, then ->STEP_B.

STEP_B (run=1):
- On cpu_idle=1 ->HALT.
- Result: exactly one instruction executes per step press.
- A stop press in STEP_A/STEP_B is ignored; the step completes.

Other rules:
- pc_load and mem_we are never asserted in the same cycle.
- Neither is asserted outside HALT.
- rst mid-operation (any state) returns to the reset values on the next edge; no partial write completes.

Decomposition:
- Package q2_panel_pkg: FSM state encoding constants (HALT, RUN, STOP_WAIT, STEP_A, STEP_B) and the press priority order.
- Sub-module q2_debounce (parameter DEBOUNCE; ports clk, rst, in, level, press), instantiated six times.
- The top level holds ptr, the FSM and the output strobes.

Test Plan:
1. WIDTH=12, DEBOUNCE=4:
   - ld with sw=0x100 -> ptr=0x100.
   - dep with sw=0xABC -> one mem_we cycle, addr 0x100, data 0xABC; ptr=0x101.
   - Second dep with sw=0x123 -> write at 0x101; ptr=0x102.
2. Debounce:
   - dep_sw high for 3 cycles -> no mem_we.
   - dep_sw held high -> mem_we exactly once, DEBOUNCE+2 cycles after the first high edge; no repeat while held.
3. Wrap: ld 0xFFF, then incp -> ptr=0x000.
4. Run/stop:
   - start -> pc_load with pc_value=ptr, run=1.
   - stop press with cpu_idle=0 -> run stays 1.
   - cpu_idle=1 for one cycle -> run=0 the next cycle, state HALT.
   - With stop_sw level held at 1, start press -> no pc_load, run stays 0.
5. Single step:
   - step with cpu_idle pattern 1,0,0,1 -> run high until cpu_idle returns to 1, then 0.
   - dep pressed during the step -> ignored.
6. Collision and reset:
   - start and dep presses in the same cycle -> pc_load only, no mem_we, ptr unchanged.
   - rst asserted while RUN -> run=0, ptr=0 the next cycle.
